jtpopeye_rommux: RTL and testbench
==================================

JTPOPEYE_ROMMUX -- requirements
Module: jtpopeye_rommux

Interface
REQ-001 Parameter CH, default 3: number of ROM client channels, 1 to 8.
REQ-002 Parameter AW, default 15: per-channel 32-bit word address width, at most 22.
REQ-003 Parameter OFFSETS, width CH*22, default 0: packed per-channel SDRAM base word addresses; channel i uses bits [22*i+21:22*i].
REQ-004 Parameter RROBIN, default 1: 1 selects round-robin arbitration, 0 selects fixed priority with the lowest index first.
REQ-005 Parameter READY_DLY, default 4: number of clk cycles from leaving download/reset until ready asserts.
REQ-006 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-007 Port rst, input, 1: synchronous, active-high reset.
REQ-008 Port downloading, input, 1: ROM load in progress; the block is held idle while high.
REQ-009 Port ch_cs, input, CH: per-channel read enable.
REQ-010 Port ch_addr, input, CH*AW: packed per-channel word addresses.
REQ-011 Port ch_dout, output, CH*32: packed per-channel cached data words.
REQ-012 Port ch_ok, output, CH: per-channel data valid for the current ch_addr.
REQ-013 Port sdram_req, output, 1: SDRAM read request level.
REQ-014 Port sdram_addr, output, 22: SDRAM word address.
REQ-015 Port sdram_ack, input, 1: one-cycle pulse; data_read is valid in the same cycle.
REQ-016 Port data_read, input, 32: SDRAM read data.
REQ-017 Port ready, output, 1: ROM subsystem usable.

Function
REQ-018 Each channel shall hold a one-entry cache: a valid bit, an AW-bit tag and 32-bit data.
REQ-019 ch_ok[i] shall be combinational: ch_cs[i] AND valid[i] AND (tag[i]==ch_addr[i]); ch_dout[i] shall always drive cached data[i].
REQ-020 A channel shall be pending when ch_cs[i] is high and its cache misses; pending is evaluated every cycle.
REQ-021 The FSM shall have two states, IDLE and WAIT.
REQ-022 In IDLE with any channel pending, the FSM shall grant one channel, latch its index and address, set sdram_addr = OFFSETS[i] + ch_addr[i] (zero-extended, truncated to 22 bits), set sdram_req=1, and enter WAIT on the next cycle.
REQ-023 With RROBIN=1, the grant search shall start at the last granted index +1, wrapping from CH-1 to 0; with RROBIN=0, the lowest pending index shall win.
REQ-024 In WAIT, sdram_req and sdram_addr shall be held until sdram_ack.
REQ-025 On sdram_ack in WAIT, the FSM shall write data_read to the granted data, set the tag to the latched address, set valid, drop sdram_req, and return to IDLE; the earliest re-grant is the following cycle.
REQ-026 If a channel's address changes while its request is in flight, the fetched data shall still be stored under the latched tag; ch_ok stays low and the channel requests again.
REQ-027 sdram_ack received in IDLE shall be ignored.
REQ-028 Miss-to-ch_ok latency shall be 1 cycle (grant) plus the SDRAM ack delay plus 1 cycle, when the arbiter is free.
REQ-029 downloading high shall clear all valid bits, force IDLE and sdram_req=0, and clear ready; if downloading coincides with sdram_ack, downloading wins and the data is discarded.
REQ-030 A counter shall assert ready after READY_DLY consecutive cycles with rst and downloading both low; ready stays high until rst or downloading.

Reset
REQ-031 rst shall set state=IDLE, sdram_req=0, sdram_addr=0, all valid=0, all tags and data=0, the round-robin pointer=CH-1 (so channel 0 is searched first), ready=0 and the ready counter=0.
REQ-032 rst asserted mid-request shall abandon the request; a later sdram_ack shall be ignored per REQ-027.

Verification
REQ-033 After reset, CH=3, OFFSETS={0,0x4000,0x8000}, ch_cs=3'b010, ch1 addr 0x0123, ack 3 cycles later with data 0xDEADBEEF -> sdram_addr=0x4123; ch_ok[1]=1 and ch_dout[1]=0xDEADBEEF the cycle after ack.
REQ-034 RROBIN=1, all three channels missing continuously -> grant order 0,1,2,0; with RROBIN=0 under the same stimulus -> channel 0 is regranted whenever pending.
REQ-035 ch0 addr changes from 0x10 to 0x11 while 0x10 is in flight -> cache tag becomes 0x10, ch_ok[0] stays 0, and the next request uses sdram_addr=0x11.
REQ-036 downloading pulsed in the same cycle as sdram_ack -> valid bits all 0, sdram_req=0, ready=0, then ready=1 exactly 4 cycles after downloading falls.
REQ-037 Hit case: after a fill, ch_addr unchanged and ch_cs held -> no new sdram_req and ch_ok stays 1; dropping ch_cs -> ch_ok=0 with no request.

Source files
------------

// File: rtl/jtpopeye_rommux.sv
// jtpopeye_rommux: shares one SDRAM read port among CH ROM clients.
// Each client keeps a single-word cache (valid/tag/data). Misses are arbitrated
// either round-robin or by fixed priority. Only one SDRAM read is in flight at a time.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no read in flight; grant a pending channel if there is one
// ST_WAIT | read issued; hold sdram_req/sdram_addr until sdram_ack
`timescale 1ns/1ps

module jtpopeye_rommux #(
  parameter int              CH        = 3,
  parameter int              AW        = 15,
  parameter logic [CH*22-1:0] OFFSETS  = '0,
  parameter bit              RROBIN    = 1'b1,
  parameter int              READY_DLY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              downloading,
  input  logic [CH-1:0]     ch_cs,
  input  logic [CH*AW-1:0]  ch_addr,
  output logic [CH*32-1:0]  ch_dout,
  output logic [CH-1:0]     ch_ok,
  output logic              sdram_req,
  output logic [21:0]       sdram_addr,
  input  logic              sdram_ack,
  input  logic [31:0]       data_read,
  output logic              ready
);

  localparam int IW = (CH > 1) ? $clog2(CH) : 1;
  localparam int CW = $clog2(READY_DLY + 2);

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [CH-1:0]   valid_q;
  logic [AW-1:0]   tag_q  [CH];
  logic [31:0]     data_q [CH];
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [AW-1:0]   gaddr_q, gaddr_d;
  logic [IW-1:0]   last_q, last_d;
  logic [21:0]     saddr_q, saddr_d;
  logic            fill;
  logic [CW-1:0]   rcnt_q;
  logic            ready_q;

  logic [AW-1:0]   addr_a [CH];
  logic [21:0]     off_a  [CH];
  logic [CH-1:0]   hit;
  logic [CH-1:0]   pending;
  logic            sel_found;
  logic [IW-1:0]   sel_idx;
  logic [IW-1:0]   cand;

  // Search order for round-robin: one past the last grant, wrapping at CH.
  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] last, input int k);
    int s;
    s = int'(last) + 1 + k;
    if (s >= CH) s = s - CH;
    return IW'(s);
  endfunction

  // Unpack per-channel addresses/offsets and evaluate hit and pending every cycle.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      addr_a[i]  = ch_addr[AW*i +: AW];
      off_a[i]   = OFFSETS[22*i +: 22];
      hit[i]     = valid_q[i] && (tag_q[i] == addr_a[i]);
      pending[i] = ch_cs[i] && !hit[i];
    end
  end

  // Arbiter: first pending channel in search order wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < CH; k++) begin
      cand = RROBIN ? rr_idx(last_q, k) : IW'(k);
      if (!sel_found && pending[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Next-state logic; downloading overrides everything, including a same-cycle ack.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gaddr_d = gaddr_q;
    last_d  = last_q;
    saddr_d = saddr_q;
    fill    = 1'b0;
    if (downloading) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sel_found) begin
            state_d = ST_WAIT;
            gnt_d   = sel_idx;
            gaddr_d = addr_a[sel_idx];
            last_d  = sel_idx;
            saddr_d = off_a[sel_idx] + 22'(addr_a[sel_idx]);
          end
        end
        ST_WAIT: begin
          if (sdram_ack) begin
            state_d = ST_IDLE;
            fill    = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      gaddr_q <= '0;
      last_q  <= IW'(CH - 1);
      saddr_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gaddr_q <= gaddr_d;
      last_q  <= last_d;
      saddr_q <= saddr_d;
    end
  end

  // Cache update: the fill is stored under the address latched at grant time.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < CH; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (downloading) begin
      valid_q <= '0;
    end else if (fill) begin
      valid_q[gnt_q] <= 1'b1;
      tag_q[gnt_q]   <= gaddr_q;
      data_q[gnt_q]  <= data_read;
    end
  end

  // Ready counter: READY_DLY quiet cycles after reset/download before ready rises.
  always_ff @(posedge clk) begin
    if (rst || downloading) begin
      rcnt_q  <= '0;
      ready_q <= 1'b0;
    end else if (!ready_q) begin
      rcnt_q <= rcnt_q + CW'(1);
      if (int'(rcnt_q) + 1 >= READY_DLY) ready_q <= 1'b1;
    end
  end

  // Outputs: request is a Moore output of WAIT; hit flags and data are combinational.
  always_comb begin
    sdram_req  = (state_q == ST_WAIT);
    sdram_addr = saddr_q;
    ready      = ready_q;
    ch_ok      = ch_cs & hit;
    for (int i = 0; i < CH; i++) ch_dout[32*i +: 32] = data_q[i];
  end

endmodule

// File: tb/tb_jtpopeye_rommux.sv
// Testbench for jtpopeye_rommux: table-driven fills plus hand-written corner sequences.
`timescale 1ns/1ps

module tb_jtpopeye_rommux;
  localparam int CH = 3;
  localparam int AW = 15;
  localparam logic [CH*22-1:0] OFFS = {22'h008000, 22'h004000, 22'h000000};
  localparam int ACK_LAT = 3;

  logic            clk = 1'b0;
  logic            rst, downloading;
  logic [CH-1:0]   ch_cs;
  logic [AW-1:0]   a0, a1, a2;
  logic [CH*AW-1:0] ch_addr;
  logic [CH*32-1:0] ch_dout, fp_dout;
  logic [CH-1:0]   ch_ok, fp_ok;
  logic            sdram_req, fp_req;
  logic [21:0]     sdram_addr, fp_addr;
  logic            sdram_ack;
  logic [31:0]     data_read;
  logic            ready, fp_ready;

  logic            resp_en, resp_ack, man_ack;
  logic [31:0]     resp_data, man_data;
  int              wait_cnt;
  logic            req_prev, fp_req_prev;

  logic [21:0]     obs_q[$];
  logic [21:0]     fp_obs_q[$];
  logic [21:0]     exp_q[$];

  int checks = 0;
  int errors = 0;

  assign ch_addr   = {a2, a1, a0};
  assign sdram_ack = resp_ack | man_ack;
  assign data_read = resp_ack ? resp_data : man_data;

  always #5 clk = ~clk;

  jtpopeye_rommux #(.CH(CH), .AW(AW), .OFFSETS(OFFS), .RROBIN(1'b1), .READY_DLY(4)) dut (
    .clk(clk), .rst(rst), .downloading(downloading), .ch_cs(ch_cs), .ch_addr(ch_addr),
    .ch_dout(ch_dout), .ch_ok(ch_ok), .sdram_req(sdram_req), .sdram_addr(sdram_addr),
    .sdram_ack(sdram_ack), .data_read(data_read), .ready(ready));

  jtpopeye_rommux #(.CH(CH), .AW(AW), .OFFSETS(OFFS), .RROBIN(1'b0), .READY_DLY(4)) dut_fp (
    .clk(clk), .rst(rst), .downloading(downloading), .ch_cs(ch_cs), .ch_addr(ch_addr),
    .ch_dout(fp_dout), .ch_ok(fp_ok), .sdram_req(fp_req), .sdram_addr(fp_addr),
    .sdram_ack(sdram_ack), .data_read(data_read), .ready(fp_ready));

  function automatic logic [31:0] model_data(input logic [21:0] a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  // SDRAM model: ack ACK_LAT cycles after the request rises.
  always @(negedge clk) begin
    if (resp_en && sdram_req && !resp_ack) begin
      if (wait_cnt == ACK_LAT - 1) begin
        resp_ack  = 1'b1;
        resp_data = model_data(sdram_addr);
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      resp_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  // Request monitor: record each new request address.
  always @(negedge clk) begin
    if (sdram_req && !req_prev) obs_q.push_back(sdram_addr);
    if (fp_req && !fp_req_prev) fp_obs_q.push_back(fp_addr);
    req_prev    = sdram_req;
    fp_req_prev = fp_req;
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  // Wait (bounded) for the next observed request and compare with the scoreboard.
  task automatic grant_cmp(input string name);
    int n = 0;
    while (obs_q.size() == 0 && n < 10) begin
      tick();
      n++;
    end
    if (obs_q.size() == 0 || exp_q.size() == 0) fail_now(name);
    else chk(name, 96'(obs_q.pop_front()), 96'(exp_q.pop_front()));
  endtask

  task automatic do_reset;
    rst = 1'b1;
    ch_cs = '0;
    man_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    obs_q.delete();
    fp_obs_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    int            ch;
    logic [AW-1:0] addr;
    logic [21:0]   exp_sa;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic got;

    vecs[0] = '{0, 15'h0000, 22'h000000};
    vecs[1] = '{1, 15'h7FFF, 22'h00BFFF};
    vecs[2] = '{2, 15'h1234, 22'h009234};
    vecs[3] = '{2, 15'h7FFF, 22'h00FFFF};
    vecs[4] = '{0, 15'h7FFF, 22'h007FFF};
    vecs[5] = '{1, 15'h0001, 22'h004001};

    rst = 1'b1; downloading = 1'b0; ch_cs = '0;
    a0 = '0; a1 = '0; a2 = '0;
    resp_en = 1'b1; resp_ack = 1'b0; resp_data = '0; wait_cnt = 0;
    man_ack = 1'b0; man_data = '0;
    req_prev = 1'b0; fp_req_prev = 1'b0;

    // Reset state and ready delay
    do_reset();
    chk("rst_req", 96'(sdram_req), 96'd0);
    chk("rst_addr", 96'(sdram_addr), 96'd0);
    chk("rst_ok", 96'(ch_ok), 96'd0);
    chk("rst_dout", ch_dout, 96'd0);
    chk("rst_ready", 96'(ready), 96'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("ready_c%0d", i), 96'(ready), (i == 4) ? 96'd1 : 96'd0);
    end

    // Table-driven single-channel fills
    for (int v = 0; v < 6; v++) begin
      exp_q.push_back(vecs[v].exp_sa);
      ch_cs = CH'(1 << vecs[v].ch);
      case (vecs[v].ch)
        0: a0 = vecs[v].addr;
        1: a1 = vecs[v].addr;
        default: a2 = vecs[v].addr;
      endcase
      n = 0; got = 1'b0;
      while (n < 20 && !got) begin
        tick();
        n++;
        got = ch_ok[vecs[v].ch];
      end
      if (!got) fail_now($sformatf("fill%0d_ok", v));
      chk($sformatf("fill%0d_lat", v), 96'(n), 96'(1 + ACK_LAT));
      grant_cmp($sformatf("fill%0d_sa", v));
      chk($sformatf("fill%0d_dout", v), 96'(ch_dout[32*vecs[v].ch +: 32]), 96'(model_data(vecs[v].exp_sa)));
    end

    // Hit: no new request while cached; dropping cs drops ok
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hit_ok", 96'(ch_ok[1]), 96'd1);
      chk("hit_noreq", 96'(sdram_req), 96'd0);
    end
    ch_cs = '0;
    #1;
    chk("nocs_ok", 96'(ch_ok), 96'd0);
    tick();
    tick();
    chk("nocs_noreq", 96'(obs_q.size()), 96'd0);

    // Arbitration: ch0 keeps missing (address moves), ch1/ch2 miss once
    do_reset();
    a0 = 15'h0010; a1 = 15'h0020; a2 = 15'h0030;
    ch_cs = 3'b111;
    n = 0;
    while (n < 80 && (obs_q.size() < 4 || fp_obs_q.size() < 4)) begin
      tick();
      a0 = a0 + 15'd1;
      n++;
    end
    if (obs_q.size() < 4 || fp_obs_q.size() < 4) fail_now("arb_count");
    else begin
      chk("rr_g0", 96'(obs_q[0][15:14]), 96'd0);
      chk("rr_g1", 96'(obs_q[1][15:14]), 96'd1);
      chk("rr_g2", 96'(obs_q[2][15:14]), 96'd2);
      chk("rr_g3", 96'(obs_q[3][15:14]), 96'd0);
      for (int k = 0; k < 4; k++) chk($sformatf("fp_g%0d", k), 96'(fp_obs_q[k][15:14]), 96'd0);
    end
    ch_cs = '0;
    n = 0;
    while (n < 10 && sdram_req) begin tick(); n++; end

    // Address changes while in flight
    do_reset();
    a0 = 15'h0010;
    ch_cs = 3'b001;
    exp_q.push_back(22'h000010);
    grant_cmp("inflt_sa0");
    a0 = 15'h0011;
    n = 0;
    while (n < 10 && sdram_req) begin tick(); n++; end
    chk("inflt_ok_new", 96'(ch_ok[0]), 96'd0);
    a0 = 15'h0010;
    #1;
    chk("inflt_tag_ok", 96'(ch_ok[0]), 96'd1);
    chk("inflt_dout", 96'(ch_dout[31:0]), 96'(model_data(22'h000010)));
    a0 = 15'h0011;
    exp_q.push_back(22'h000011);
    grant_cmp("inflt_sa1");
    n = 0;
    while (n < 10 && !ch_ok[0]) begin tick(); n++; end
    chk("inflt_ok2", 96'(ch_ok[0]), 96'd1);

    // Ack while idle is ignored
    resp_en = 1'b0;
    tick();
    man_ack = 1'b1; man_data = 32'hCAFEF00D;
    tick();
    man_ack = 1'b0;
    chk("idleack_dout", 96'(ch_dout[31:0]), 96'(model_data(22'h000011)));
    chk("idleack_ok", 96'(ch_ok[0]), 96'd1);

    // Directed fill with known data
    do_reset();
    a1 = 15'h0123;
    ch_cs = 3'b010;
    exp_q.push_back(22'h004123);
    tick();
    chk("dir_req", 96'(sdram_req), 96'd1);
    grant_cmp("dir_sa");
    tick();
    tick();
    man_ack = 1'b1; man_data = 32'hDEADBEEF;
    tick();
    man_ack = 1'b0;
    chk("dir_ok", 96'(ch_ok[1]), 96'd1);
    chk("dir_dout", 96'(ch_dout[63:32]), 96'h0DEADBEEF);
    chk("dir_reqlow", 96'(sdram_req), 96'd0);

    // Download coinciding with ack
    a1 = 15'h0124;
    exp_q.push_back(22'h004124);
    tick();
    grant_cmp("dl_sa");
    tick();
    man_ack = 1'b1; man_data = 32'h11112222; downloading = 1'b1;
    tick();
    man_ack = 1'b0; downloading = 1'b0;
    chk("dl_req", 96'(sdram_req), 96'd0);
    chk("dl_ready", 96'(ready), 96'd0);
    a1 = 15'h0123;
    ch_cs = 3'b111;
    #1;
    chk("dl_valid", 96'(ch_ok), 96'd0);
    chk("dl_dout", 96'(ch_dout[63:32]), 96'h0DEADBEEF);
    ch_cs = '0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("dl_ready_c%0d", i), 96'(ready), (i == 4) ? 96'd1 : 96'd0);
    end

    // Reset mid-request abandons it; late ack ignored
    do_reset();
    a0 = 15'h0055;
    ch_cs = 3'b001;
    tick();
    chk("rstmid_req", 96'(sdram_req), 96'd1);
    rst = 1'b1;
    tick();
    chk("rstmid_reqlow", 96'(sdram_req), 96'd0);
    rst = 1'b0;
    man_ack = 1'b1; man_data = 32'h12345678;
    tick();
    man_ack = 1'b0;
    chk("rstmid_dout", 96'(ch_dout[31:0]), 96'd0);
    chk("rstmid_ok", 96'(ch_ok[0]), 96'd0);
    ch_cs = '0;
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
